// File: rtl/ieee754_div_pkg.sv
// Shared definitions for the IEEE-754 mantissa divider.
// Holds the default mantissa width (hidden bit included) and the
// sequencer state encoding used by mant_div_seq.
package ieee754_div_pkg;

    localparam int MANT_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/mant_div_seq.sv
// Sequential restoring divider for normalized floating-point mantissas.
// Produces one quotient bit per cycle, MSB first, on a serial strobe that
// feeds a quotient shift register owned by the parent block.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request a division (honoured only while idle)
//   dividend  normalized dividend mantissa (hidden bit at MANT_W-1)
//   divisor   normalized divisor mantissa
//   busy      high from LOAD through the last DIV cycle
//   done      one-cycle completion pulse
//   err       divisor was zero (held until the next accepted start)
//   q_ld      parallel-load strobe for the downstream quotient register
//   q_in      parallel-load value (always zero)
//   q_sld     shift strobe for the downstream quotient register
//   q_sin     serial quotient bit, valid while q_sld is high
//   sticky    final remainder was nonzero (held until the next start)
import ieee754_div_pkg::*;

module mant_div_seq #(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              q_ld,
    output logic [MANT_W-1:0] q_in,
    output logic              q_sld,
    output logic              q_sin,
    output logic              sticky
);

    localparam int CNT_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;

    div_state_t        state, state_nxt;
    logic [MANT_W:0]   r_q;
    logic [MANT_W-1:0] d_q;
    logic [CNT_W-1:0]  cnt;
    logic              r_ge;
    logic              last_step;
    logic [MANT_W:0]   r_step;

    // One restoring step: subtract when the divisor fits, then shift left.
    // With both operands normalized R stays below 2*D, so the MSB of the
    // shifted result is never lost.
    function automatic logic [MANT_W:0] rem_step(input logic [MANT_W:0]   r,
                                                 input logic [MANT_W-1:0] d);
        logic [MANT_W:0] t;
        t = (r >= {1'b0, d}) ? (r - {1'b0, d}) : r;
        return {t[MANT_W-1:0], 1'b0};
    endfunction

    assign r_ge      = (r_q >= {1'b0, d_q});
    assign r_step    = rem_step(r_q, d_q);
    assign last_step = (cnt == CNT_W'(MANT_W - 1));
    assign q_in      = '0;

    // Next-state and Moore-style strobe decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        q_ld      = 1'b0;
        q_sld     = 1'b0;
        q_sin     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                q_ld      = 1'b1;
                state_nxt = ST_DIV;
            end
            ST_DIV: begin
                busy  = 1'b1;
                q_sld = 1'b1;
                q_sin = r_ge;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state, remainder, step counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            r_q    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        r_q    <= {1'b0, dividend};
                        sticky <= 1'b0;
                        err    <= (divisor == '0);
                    end
                end
                ST_LOAD: begin
                    cnt <= '0;
                end
                ST_DIV: begin
                    r_q <= r_step;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        sticky <= (r_step != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Divisor is pure data: captured on acceptance, no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            d_q <= divisor;
        end
    end

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq: directed vectors, zero divisor,
// reset behaviour and randomized normalized operands against an
// arithmetic reference model of the quotient and sticky bit.
module tb_mant_div_seq;

    localparam int MANT_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [MANT_W-1:0] dividend;
    logic [MANT_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic              err;
    logic              q_ld;
    logic [MANT_W-1:0] q_in;
    logic              q_sld;
    logic              q_sin;
    logic              sticky;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [MANT_W-1:0] q;
        logic              stk;
        logic              err_done;
        logic              err_end;
        int                done_cyc;
        int                ndone;
        int                nld;
        int                nsld;
        int                viol;
        int                busy_bad;
    } res_t;

    always #5 clk = ~clk;

    mant_div_seq #(.MANT_W(MANT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .q_ld     (q_ld),
        .q_in     (q_in),
        .q_sld    (q_sld),
        .q_sin    (q_sin),
        .sticky   (sticky)
    );

    function automatic logic [MANT_W-1:0] ref_q(input logic [MANT_W-1:0] a,
                                                input logic [MANT_W-1:0] b);
        longint unsigned n;
        longint unsigned qq;
        n  = longint'(a) << (MANT_W - 1);
        qq = n / longint'(b);
        return qq[MANT_W-1:0];
    endfunction

    function automatic logic ref_stk(input logic [MANT_W-1:0] a,
                                     input logic [MANT_W-1:0] b);
        longint unsigned n;
        n = longint'(a) << (MANT_W - 1);
        return (n % longint'(b)) != 0;
    endfunction

    function automatic logic [MANT_W-1:0] rand_norm();
        logic [MANT_W-1:0] v;
        v = MANT_W'($urandom);
        v[MANT_W-1] = 1'b1;
        return v;
    endfunction

    // Drives one start and observes a fixed window of cycles, modelling the
    // downstream quotient shift register. Cycle 0 is the accepting cycle.
    task automatic run_op(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                          input int start_cyc, input int rst_cyc, output res_t r);
        r = '{q: '0, stk: 1'b0, err_done: 1'b0, err_end: 1'b0, done_cyc: -1,
              ndone: 0, nld: 0, nsld: 0, viol: 0, busy_bad: 0};
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = MANT_W'($urandom);
        divisor  = MANT_W'($urandom);
        for (int cyc = 1; cyc <= MANT_W + 4; cyc++) begin
            logic exp_busy;
            exp_busy = (b != '0) && (cyc <= MANT_W + 1) && (rst_cyc < 0 || cyc <= rst_cyc);
            if (busy !== exp_busy) r.busy_bad++;
            if ((q_ld && q_sld) || (q_sin && !q_sld)) r.viol++;
            if (q_ld) begin
                r.q = q_in;
                r.nld++;
            end
            if (q_sld) begin
                r.q = {r.q[MANT_W-2:0], q_sin};
                r.nsld++;
            end
            if (done) begin
                r.ndone++;
                if (r.done_cyc < 0) begin
                    r.done_cyc = cyc;
                    r.err_done = err;
                end
            end
            start = (cyc == start_cyc);
            rst   = (cyc == rst_cyc);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        rst       = 1'b0;
        r.stk     = sticky;
        r.err_end = err;
    endtask

    task automatic test_reset();
        res_t r;
        run_op(24'h800000, 24'hC00000, -1, -1, r);
        checks++;
        if (r.stk !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_sticky got %b want 1", r.stk);
        end
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 24'h800000;
        divisor  = 24'h800000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, sticky, q_ld, q_sld, q_sin} !== 7'b0) begin
            errors++;
            $display("FAIL rst_outputs got %b want 0000000",
                     {busy, done, err, sticky, q_ld, q_sld, q_sin});
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, q_ld} !== 3'b0) begin
            errors++;
            $display("FAIL rst_priority got %b want 000", {busy, done, q_ld});
        end
    endtask

    task automatic test_directed();
        logic [MANT_W-1:0] va [4] = '{24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF};
        logic [MANT_W-1:0] vb [4] = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000};
        logic [MANT_W-1:0] vq [4] = '{24'h800000, 24'hC00000, 24'h555555, 24'hFFFFFF};
        logic              vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        res_t r;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], (i == 3) ? 10 : -1, -1, r);
            checks++;
            if (r.q !== vq[i]) begin
                errors++;
                $display("FAIL dir_q[%0d] got %h want %h", i, r.q, vq[i]);
            end
            checks++;
            if (r.stk !== vs[i]) begin
                errors++;
                $display("FAIL dir_sticky[%0d] got %b want %b", i, r.stk, vs[i]);
            end
            checks++;
            if (r.done_cyc !== MANT_W + 2 || r.ndone !== 1) begin
                errors++;
                $display("FAIL dir_done[%0d] got cyc %0d n %0d want cyc %0d n 1",
                         i, r.done_cyc, r.ndone, MANT_W + 2);
            end
            checks++;
            if (r.nld !== 1 || r.nsld !== MANT_W) begin
                errors++;
                $display("FAIL dir_strobes[%0d] got ld %0d sld %0d want 1 %0d",
                         i, r.nld, r.nsld, MANT_W);
            end
            checks++;
            if (r.viol !== 0 || r.busy_bad !== 0 || r.err_end !== 1'b0) begin
                errors++;
                $display("FAIL dir_ctrl[%0d] got viol %0d busy_bad %0d err %b want 0 0 0",
                         i, r.viol, r.busy_bad, r.err_end);
            end
        end
    endtask

    task automatic test_zero_div();
        res_t r;
        logic [MANT_W-1:0] a;
        run_op(rand_norm(), '0, -1, -1, r);
        checks++;
        if (r.done_cyc !== 1 || r.err_done !== 1'b1 || r.err_end !== 1'b1) begin
            errors++;
            $display("FAIL zero_err got cyc %0d err %b/%b want cyc 1 err 1/1",
                     r.done_cyc, r.err_done, r.err_end);
        end
        checks++;
        if (r.nld !== 0 || r.nsld !== 0 || r.busy_bad !== 0 || r.ndone !== 1) begin
            errors++;
            $display("FAIL zero_strobes got ld %0d sld %0d busy_bad %0d done %0d want 0 0 0 1",
                     r.nld, r.nsld, r.busy_bad, r.ndone);
        end
        a = rand_norm();
        run_op(a, 24'h800000, -1, -1, r);
        checks++;
        if (r.err_end !== 1'b0 || r.q !== ref_q(a, 24'h800000)) begin
            errors++;
            $display("FAIL zero_clear got err %b q %h want err 0 q %h",
                     r.err_end, r.q, ref_q(a, 24'h800000));
        end
    endtask

    task automatic test_rst_mid();
        res_t r;
        logic [MANT_W-1:0] a, b;
        run_op(rand_norm(), rand_norm(), -1, 12, r);
        checks++;
        if (r.ndone !== 0 || r.nsld !== 11 || r.busy_bad !== 0 || r.viol !== 0) begin
            errors++;
            $display("FAIL rstmid got done %0d sld %0d busy_bad %0d viol %0d want 0 11 0 0",
                     r.ndone, r.nsld, r.busy_bad, r.viol);
        end
        a = rand_norm();
        b = rand_norm();
        run_op(a, b, -1, -1, r);
        checks++;
        if (r.q !== ref_q(a, b) || r.stk !== ref_stk(a, b) || r.done_cyc !== MANT_W + 2) begin
            errors++;
            $display("FAIL rstmid_after got q %h s %b cyc %0d want q %h s %b cyc %0d",
                     r.q, r.stk, r.done_cyc, ref_q(a, b), ref_stk(a, b), MANT_W + 2);
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [MANT_W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = rand_norm();
            b = rand_norm();
            run_op(a, b, $urandom_range(3, MANT_W), -1, r);
            checks++;
            if (r.q !== ref_q(a, b) || r.stk !== ref_stk(a, b)) begin
                errors++;
                $display("FAIL rand_q[%0d] %h/%h got q %h s %b want q %h s %b",
                         i, a, b, r.q, r.stk, ref_q(a, b), ref_stk(a, b));
            end
            checks++;
            if (r.done_cyc !== MANT_W + 2 || r.nsld !== MANT_W || r.viol !== 0 || r.busy_bad !== 0) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got cyc %0d sld %0d viol %0d busy_bad %0d",
                         i, r.done_cyc, r.nsld, r.viol, r.busy_bad);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_zero_div();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mant_div_seq.md
MANT_DIV_SEQ -- requirements
Module: mant_div_seq

Interface
REQ-001 Parameter MANT_W, default 24, SHALL set the mantissa width (hidden bit at MANT_W-1, fraction below it).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new division; sampled only in IDLE.
REQ-005 dividend  input  MANT_W  SHALL be the normalized dividend mantissa; sampled on the accepting edge.
REQ-006 divisor  input  MANT_W  SHALL be the normalized divisor mantissa; sampled on the accepting edge.
REQ-007 busy  output  1  SHALL be high from the cycle after acceptance through the last DIV cycle.
REQ-008 done  output  1  SHALL pulse for one cycle at completion.
REQ-009 err  output  1  SHALL flag a zero divisor.
REQ-010 q_ld, q_in  output  1, MANT_W  SHALL be the parallel-load strobe and load value for the downstream quotient shift register; q_in is constant zero.
REQ-011 q_sld, q_sin  output  1, 1  SHALL be the shift strobe and serial quotient bit for that register.
REQ-012 sticky  output  1  SHALL be high when the final remainder is nonzero.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, DIV and DONE.
REQ-014 In IDLE with start=1, the FSM SHALL capture the operands into remainder register R (MANT_W+1 bits, zero-extended dividend) and divisor register D, clear sticky and err, and go to LOAD, or go to DONE if divisor==0.
REQ-015 LOAD SHALL last one cycle with q_ld=1, the step counter cleared, and a transition to DIV.
REQ-016 DIV SHALL last exactly MANT_W cycles with q_sld=1 in each cycle.
REQ-017 Each DIV cycle SHALL drive q_sin=(R>=D), set R to ((R>=D) ? R-D : R)<<1, and increment the counter.
REQ-018 Quotient bits SHALL be emitted MSB first.
REQ-019 The FSM SHALL leave DIV after counter value MANT_W-1, capturing sticky=(updated R!=0), and go to DONE.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE unconditionally.
REQ-021 start in LOAD, DIV or DONE SHALL be ignored.
REQ-022 Latency SHALL be: acceptance in cycle 0, q_ld in cycle 1, q_sld in cycles 2..MANT_W+1, and done in cycle MANT_W+2, when the downstream register holds floor(dividend*2^(MANT_W-1)/divisor).
REQ-023 For a zero divisor, the block SHALL assert err=1 with done in cycle 1 and SHALL assert no q_ld or q_sld.
REQ-024 err and sticky SHALL hold their values until the next accepted start.
REQ-025 q_ld and q_sld SHALL never be high in the same cycle; both SHALL be 0 outside LOAD and DIV.
REQ-026 q_sin SHALL be 0 whenever q_sld=0.
REQ-027 Operand changes after acceptance SHALL not affect the result.

Reset
REQ-028 rst=1 SHALL force IDLE and set busy, done, err, sticky, q_ld, q_sld, q_sin, the counter and R to 0 on the next edge.
REQ-029 rst SHALL take priority over start.
REQ-030 rst mid-operation SHALL abort the operation, emit no further strobes, and produce no done pulse.

Structure
REQ-031 The MANT_W default and the state encoding SHALL reside in shared package ieee754_div_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the quotient shift register SHALL be instantiated by the parent, not inside this block.

Verification
REQ-033 0x800000 / 0x800000 -> serial bits 1 then 23 zeros, Q=0x800000, sticky=0, done in cycle 26.
REQ-034 0xC00000 / 0x800000 -> Q=0xC00000, sticky=0.
REQ-035 0x800000 / 0xC00000 -> bits 0,1,0,1,..., Q=0x555555, sticky=1.
REQ-036 0xFFFFFF / 0x800000 -> Q=0xFFFFFF, sticky=0; start pulsed in cycle 10 -> ignored, result unchanged.
REQ-037 divisor=0 -> err=1 and done in cycle 1, no q_ld or q_sld; the next valid start clears err.
REQ-038 rst in cycle 12 of a division -> busy=0 and q_sld=0 from cycle 13, no done; a following start yields a correct result.
